// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the pipelined CPU control path.
//   ctrl_state_t : pipeline controller FSM encoding (RUN / MEMWAIT / HALT)
//   ZERO_REG_IDX : architectural zero register, never a hazard source
//   TIMEOUT_W    : width of the memory-wait counter
//   ctrl_out_t   : bundle of the controller's 1-bit pipeline controls
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    HALT    = 2'b10
  } ctrl_state_t;

  localparam logic [4:0] ZERO_REG_IDX = 5'd31;
  localparam int         TIMEOUT_W    = 8;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_hold;
    logic memwb_bubble;
  } ctrl_out_t;

  // Control vectors for each pipeline action.
  localparam ctrl_out_t CTRL_IDLE   = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                        idex_bubble: 1'b0, pipe_hold: 1'b0, memwb_bubble: 1'b0};
  localparam ctrl_out_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                        idex_bubble: 1'b0, pipe_hold: 1'b1, memwb_bubble: 1'b1};
  localparam ctrl_out_t CTRL_STALL  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                        idex_bubble: 1'b1, pipe_hold: 1'b0, memwb_bubble: 1'b0};
  localparam ctrl_out_t CTRL_FLUSH  = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                        idex_bubble: 1'b0, pipe_hold: 1'b0, memwb_bubble: 1'b0};
  localparam ctrl_out_t CTRL_RESET  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                                        idex_bubble: 1'b1, pipe_hold: 1'b0, memwb_bubble: 1'b1};

endpackage

// File: rtl/load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard comparator between the load in EX and the
// source registers of the instruction in ID.
//   ex_mem_read : EX instruction is a load
//   ex_rd       : EX destination register
//   id_rn       : ID first source register
//   id_rm       : ID second source register (post Reg2Loc mux)
//   id_rm_used  : ID instruction actually reads id_rm
//   load_use    : hazard present
// -----------------------------------------------------------------------------
module load_use_detect
  import cpu_pkg::*;
#(
  parameter logic [4:0] ZERO_REG = ZERO_REG_IDX
) (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rn,
  input  logic [4:0] id_rm,
  input  logic       id_rm_used,
  output logic       load_use
);

  logic w_rn_hit;
  logic w_rm_hit;

  assign w_rn_hit = (ex_rd == id_rn);
  assign w_rm_hit = id_rm_used && (ex_rd == id_rm);

  // The zero register is hard-wired, so a load targeting it never produces
  // a value the consumer must wait for.
  assign load_use = ex_mem_read && (ex_rd != ZERO_REG) && (w_rn_hit || w_rm_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Pipeline hazard / memory-wait controller. Combinational control outputs from
// the registered FSM state; the FSM tracks outstanding data-memory accesses and
// halts the core if memory never responds.
//   clk, reset         : clock, synchronous active-high reset
//   id_rn/id_rm/_used  : ID source registers
//   id_br_taken        : branch resolved taken in ID
//   ex_mem_read, ex_rd : EX load and its destination
//   mem_req, mem_ready : MEM-stage access request and completion
//   pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, memwb_bubble
//                      : pipeline register controls
//   halted             : controller in HALT
//   wait_cnt           : current memory-wait cycle count
// -----------------------------------------------------------------------------
module pipeline_ctrl
  import cpu_pkg::*;
#(
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 8'd255,
  parameter logic [4:0]           ZERO_REG       = ZERO_REG_IDX
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           id_rn,
  input  logic [4:0]           id_rm,
  input  logic                 id_rm_used,
  input  logic                 id_br_taken,
  input  logic                 ex_mem_read,
  input  logic [4:0]           ex_rd,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 ifid_flush,
  output logic                 idex_bubble,
  output logic                 pipe_hold,
  output logic                 memwb_bubble,
  output logic                 halted,
  output logic [TIMEOUT_W-1:0] wait_cnt
);

  ctrl_state_t          r_state;
  ctrl_state_t          w_state_nxt;
  logic [TIMEOUT_W-1:0] r_wait_cnt;
  logic [TIMEOUT_W-1:0] w_wait_cnt_nxt;

  logic      w_load_use;
  logic      w_freeze;
  logic      w_eval_hazards;
  ctrl_out_t w_ctrl;

  load_use_detect #(
    .ZERO_REG (ZERO_REG)
  ) u_load_use_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rn       (id_rn),
    .id_rm       (id_rm),
    .id_rm_used  (id_rm_used),
    .load_use    (w_load_use)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Freeze covers the first cycle of a missed access too (RUN, not ready), so
  // nothing downstream advances past an incomplete memory operation.
  assign w_freeze = ((r_state == RUN)     &&  mem_req && !mem_ready) ||
                    ((r_state == MEMWAIT) && !mem_ready)             ||
                     (r_state == HALT);

  // The MEMWAIT release cycle behaves as RUN for hazard evaluation.
  assign w_eval_hazards = (r_state == RUN) || ((r_state == MEMWAIT) && mem_ready);

  // Next state / wait counter
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    unique case (r_state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          w_state_nxt    = MEMWAIT;
          w_wait_cnt_nxt = TIMEOUT_W'(1);
        end
      end
      MEMWAIT: begin
        if (mem_ready) begin
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt < TIMEOUT_CYCLES) begin
          w_wait_cnt_nxt = r_wait_cnt + TIMEOUT_W'(1);
        end else begin
          // Timed out: counter keeps the final value for post-mortem.
          w_state_nxt = HALT;
        end
      end
      HALT: begin
        w_state_nxt = HALT;
      end
      default: begin
        w_state_nxt    = RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  // Output decode: reset > freeze > load-use > branch flush.
  always_comb begin
    w_ctrl = CTRL_IDLE;
    if (reset) begin
      w_ctrl = CTRL_RESET;
    end else if (w_freeze) begin
      w_ctrl = CTRL_FREEZE;
    end else if (w_eval_hazards && w_load_use) begin
      // A held ID instruction re-raises any suppressed branch next cycle.
      w_ctrl = CTRL_STALL;
    end else if (w_eval_hazards && id_br_taken) begin
      w_ctrl = CTRL_FLUSH;
    end
  end

  assign pc_write     = w_ctrl.pc_write;
  assign ifid_write   = w_ctrl.ifid_write;
  assign ifid_flush   = w_ctrl.ifid_flush;
  assign idex_bubble  = w_ctrl.idex_bubble;
  assign pipe_hold    = w_ctrl.pipe_hold;
  assign memwb_bubble = w_ctrl.memwb_bubble;
  assign halted       = !reset && (r_state == HALT);
  assign wait_cnt     = r_wait_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed bench for pipeline_ctrl (TIMEOUT_CYCLES=4). Each step drives inputs
// one time unit after a rising edge, queues the expected outputs, and compares
// them mid-cycle. Output vector order:
//   {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, memwb_bubble, halted}
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rn, id_rm, ex_rd;
  logic       id_rm_used, id_br_taken, ex_mem_read, mem_req, mem_ready;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, memwb_bubble, halted;
  logic [7:0] wait_cnt;

  pipeline_ctrl #(
    .TIMEOUT_CYCLES (8'd4),
    .ZERO_REG       (5'd31)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_rm_used   (id_rm_used),
    .id_br_taken  (id_br_taken),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .pipe_hold    (pipe_hold),
    .memwb_bubble (memwb_bubble),
    .halted       (halted),
    .wait_cnt     (wait_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] IDLE  = 7'b1100000;
  localparam logic [6:0] STALL = 7'b0001000;
  localparam logic [6:0] FLUSH = 7'b1110000;
  localparam logic [6:0] FRZ   = 7'b0000110;
  localparam logic [6:0] FRZH  = 7'b0000111;
  localparam logic [6:0] RST   = 7'b0011010;

  typedef struct {
    logic [6:0] outs;
    logic [7:0] cnt;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Drive one cycle of stimulus, queue its expectation, then check it.
  task automatic step(input logic rst, input logic mreq, input logic mrdy,
                      input logic exmr, input logic [4:0] exrd,
                      input logic [4:0] rn, input logic [4:0] rm, input logic rmu,
                      input logic br, input logic [6:0] eo, input logic [7:0] ec,
                      input string tag);
    exp_t e;
    exp_t got;
    logic [6:0] obs;
    @(posedge clk);
    #1;
    reset = rst; mem_req = mreq; mem_ready = mrdy;
    ex_mem_read = exmr; ex_rd = exrd; id_rn = rn; id_rm = rm;
    id_rm_used = rmu; id_br_taken = br;
    e.outs = eo; e.cnt = ec; e.tag = tag;
    exp_q.push_back(e);
    #3;
    got = exp_q.pop_front();
    obs = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, memwb_bubble, halted};
    n_chk++;
    assert (obs === got.outs) n_pass++;
    else $error("FAIL %s.ctrl observed=%b expected=%b", got.tag, obs, got.outs);
    n_chk++;
    assert (wait_cnt === got.cnt) n_pass++;
    else $error("FAIL %s.wait_cnt observed=%0d expected=%0d", got.tag, wait_cnt, got.cnt);
  endtask

  initial begin
    reset = 1'b1; mem_req = 1'b0; mem_ready = 1'b0; ex_mem_read = 1'b0;
    ex_rd = 5'd0; id_rn = 5'd0; id_rm = 5'd0; id_rm_used = 1'b0; id_br_taken = 1'b0;

    //   rst mreq mrdy exmr exrd  rn    rm    rmu br    outs  cnt  tag
    step(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, RST,   8'd0, "reset");
    step(0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, IDLE,  8'd0, "idle");
    // Load-use on Rn, then the same pattern through the zero register
    step(0, 0, 0, 1, 5'd3,  5'd3,  5'd0,  0, 0, STALL, 8'd0, "lu_rn");
    step(0, 0, 0, 0, 5'd3,  5'd3,  5'd0,  0, 0, IDLE,  8'd0, "lu_clear");
    step(0, 0, 0, 1, 5'd31, 5'd31, 5'd31, 1, 0, IDLE,  8'd0, "lu_zero");
    // Branch flush, branch+load-use on Rm, unused Rm match
    step(0, 0, 0, 0, 5'd0,  5'd1,  5'd2,  0, 1, FLUSH, 8'd0, "br");
    step(0, 0, 0, 1, 5'd5,  5'd0,  5'd5,  1, 1, STALL, 8'd0, "br_lu_rm");
    step(0, 0, 0, 1, 5'd5,  5'd0,  5'd5,  0, 1, FLUSH, 8'd0, "rm_unused");
    // Memory hit in RUN: no freeze
    step(0, 1, 1, 0, 5'd0,  5'd0,  5'd0,  0, 0, IDLE,  8'd0, "mem_hit");
    // Miss: three low cycles then release
    step(0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, FRZ,   8'd0, "miss_c0");
    step(0, 1, 0, 1, 5'd3,  5'd3,  5'd0,  0, 1, FRZ,   8'd1, "miss_c1");
    step(0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, FRZ,   8'd2, "miss_c2");
    step(0, 1, 1, 0, 5'd0,  5'd0,  5'd0,  0, 0, IDLE,  8'd3, "release");
    step(0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, IDLE,  8'd0, "post_rel");
    // Release cycle with load-use and branch: stall first, flush next
    step(0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, FRZ,   8'd0, "miss2_c0");
    step(0, 1, 1, 1, 5'd7,  5'd7,  5'd0,  0, 1, STALL, 8'd1, "rel_lu_br");
    step(0, 0, 0, 0, 5'd7,  5'd7,  5'd0,  0, 1, FLUSH, 8'd0, "rel_flush");
    // Timeout into HALT
    step(0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, FRZ,   8'd0, "to_c0");
    step(0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, FRZ,   8'd1, "to_c1");
    step(0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, FRZ,   8'd2, "to_c2");
    step(0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, FRZ,   8'd3, "to_c3");
    step(0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, FRZ,   8'd4, "to_c4");
    step(0, 1, 1, 0, 5'd0,  5'd0,  5'd0,  0, 0, FRZH,  8'd4, "halt_rdy");
    step(0, 0, 1, 1, 5'd3,  5'd3,  5'd0,  0, 1, FRZH,  8'd4, "halt_sticky");
    // Reset out of HALT
    step(1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, RST,   8'd4, "halt_rst");
    step(0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, IDLE,  8'd0, "halt_rst_idle");
    // Reset mid-MEMWAIT abandons the access
    step(0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, FRZ,   8'd0, "mw_c0");
    step(0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, FRZ,   8'd1, "mw_c1");
    step(1, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, RST,   8'd2, "mw_rst");
    step(0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, IDLE,  8'd0, "mw_rst_idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
